// File: rtl/oam_dma_sink_if.sv
// oam_dma_sink_if: DMA byte stream, PPU read port and CPU FE00-FE9F port.
// master drives requests and data; slave (the sink) returns read data and status.
interface oam_dma_sink_if;
  logic       dma_run;
  logic       dma_strobe;
  logic [7:0] dma_a;
  logic [7:0] dma_wdata;
  logic       ppu_rd;
  logic [7:0] ppu_a;
  logic [7:0] ppu_rdata;
  logic       cpu_sel;
  logic       cpu_rd;
  logic       cpu_wr;
  logic [7:0] cpu_a;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       oam_busy;
  logic       dma_done;
  logic       overrun;
  logic [7:0] byte_count;

  modport master (
    output dma_run, dma_strobe, dma_a, dma_wdata,
    output ppu_rd, ppu_a,
    output cpu_sel, cpu_rd, cpu_wr, cpu_a, cpu_wdata,
    input  ppu_rdata, cpu_rdata,
    input  oam_busy, dma_done, overrun, byte_count
  );

  modport slave (
    input  dma_run, dma_strobe, dma_a, dma_wdata,
    input  ppu_rd, ppu_a,
    input  cpu_sel, cpu_rd, cpu_wr, cpu_a, cpu_wdata,
    output ppu_rdata, cpu_rdata,
    output oam_busy, dma_done, overrun, byte_count
  );
endinterface

// File: rtl/oam_dma_sink.sv
// oam_dma_sink: OAM DMA receiver, 2-deep write FIFO into a 160x8 OAM array.
// Ports: clk1, reset (sync, active-high), bus (oam_dma_sink_if.slave).
// Port priority: PPU read > FIFO write > CPU access; one access per cycle.
// Define OAM_DMA_CPU_BLOCK_EN to block CPU array access while oam_busy.
module oam_dma_sink (
  input logic           clk1,
  input logic           reset,
  oam_dma_sink_if.slave bus
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  state_t     state;
  logic       run_q;
  logic       busy_q;
  logic       done_q;
  logic       ovr_q;
  logic [7:0] bcnt;
  logic [7:0] ppu_q;
  logic [7:0] cpu_q;

  logic [7:0] fa [2];
  logic [7:0] fd [2];
  logic       wp;
  logic       rp;
  logic [1:0] cnt;

  logic [7:0] mem [0:159];

  logic       rise;
  logic       fall;
  logic       ppu_win;
  logic       pop;
  logic       take;
  logic       full;
  logic       push;
  logic       ovf;
  logic       blocked;
  logic       cpu_go;
  logic       ovr_clr;
  logic       mem_we;
  logic [7:0] mem_wa;
  logic [7:0] mem_wd;
  logic [7:0] bcnt_nxt;
  logic [1:0] cnt_nxt;

  assign rise    = bus.dma_run & ~run_q;
  assign fall    = ~bus.dma_run & run_q;
  assign ppu_win = bus.ppu_rd && (bus.ppu_a < 8'hA0);
  assign pop     = !ppu_win && (cnt != 2'd0);
  assign take    = (state == XFER) && bus.dma_strobe;
  assign full    = (cnt == 2'd2);
  assign push    = take && !full && (bus.dma_a < 8'hA0);
  assign ovf     = take && full;

`ifdef OAM_DMA_CPU_BLOCK_EN
  assign blocked = busy_q;
`else
  assign blocked = 1'b0;
`endif

  assign cpu_go  = bus.cpu_sel && !ppu_win && !pop &&
                   (bus.cpu_a < 8'hA0) && !blocked;
  // 0xFF sits outside the array, so it doubles as the overrun clear
  assign ovr_clr = bus.cpu_sel && bus.cpu_wr && (bus.cpu_a == 8'hFF);

  assign bcnt_nxt = (push && bcnt != 8'hA0) ? bcnt + 8'd1 : bcnt;
  assign cnt_nxt  = cnt + {1'b0, push} - {1'b0, pop};

  assign mem_we = !reset && (pop || (cpu_go && bus.cpu_wr));
  assign mem_wa = pop ? fa[rp] : bus.cpu_a;
  assign mem_wd = pop ? fd[rp] : bus.cpu_wdata;

  always_ff @(posedge clk1) begin
    if (reset) begin
      state  <= IDLE;
      run_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
      bcnt   <= 8'd0;
    end else begin
      run_q  <= bus.dma_run;
      done_q <= 1'b0;
      bcnt   <= bcnt_nxt;
      if (ovf)
        ovr_q <= 1'b1;
      else if (ovr_clr)
        ovr_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            state  <= XFER;
            busy_q <= 1'b1;
            bcnt   <= 8'd0;
          end
        end
        XFER: begin
          // the byte arriving with the falling edge is still taken
          if (fall || bcnt_nxt == 8'hA0)
            state <= DRAIN;
        end
        DRAIN: begin
          if (rise) begin
            state <= XFER;
            bcnt  <= 8'd0;
          end else if (cnt_nxt == 2'd0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      cnt <= 2'd0;
      wp  <= 1'b0;
      rp  <= 1'b0;
    end else begin
      if (push) begin
        fa[wp] <= bus.dma_a;
        fd[wp] <= bus.dma_wdata;
        wp     <= ~wp;
      end
      if (pop)
        rp <= ~rp;
      cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk1) begin
    if (mem_we)
      mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      ppu_q <= 8'hFF;
      cpu_q <= 8'hFF;
    end else begin
      if (bus.ppu_rd)
        ppu_q <= ppu_win ? mem[bus.ppu_a] : 8'hFF;
      if (bus.cpu_sel && bus.cpu_rd)
        cpu_q <= (cpu_go && !bus.cpu_wr) ? mem[bus.cpu_a] : 8'hFF;
    end
  end

  assign bus.ppu_rdata  = ppu_q;
  assign bus.cpu_rdata  = cpu_q;
  assign bus.oam_busy   = busy_q;
  assign bus.dma_done   = done_q;
  assign bus.overrun    = ovr_q;
  assign bus.byte_count = bcnt;

endmodule

// File: tb/tb_oam_dma_sink.sv
// tb_oam_dma_sink: directed bench for oam_dma_sink with a queue-based model
// checked every cycle, plus hand-computed literal expectations.
module tb_oam_dma_sink;

  logic clk1 = 1'b0;
  logic reset = 1'b1;

  oam_dma_sink_if bus();

  oam_dma_sink dut (
    .clk1  (clk1),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk1 = ~clk1;

  int total = 0;
  int bad = 0;
  int n_done = 0;
  bit started = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } ent_t;

  logic [7:0] m_mem [160];
  ent_t       q [$];
  int         m_phase;
  bit         m_prev;
  int         m_cnt;
  bit         m_ovr;
  bit         m_done;
  logic [7:0] m_ppu;
  logic [7:0] m_cpu;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: pending writes as a queue, transfer phase 0/1/2 = idle/taking/draining
  always @(posedge clk1) begin
    bit pw, popn, go, full, rise, fall, blk, ovset;
    ent_t e;
    if (reset) begin
      q.delete();
      m_phase = 0;
      m_cnt   = 0;
      m_ovr   = 0;
      m_done  = 0;
      m_ppu   = 8'hFF;
      m_cpu   = 8'hFF;
      m_prev  = 0;
      started = 1;
    end else begin
      rise   = bus.dma_run && !m_prev;
      fall   = !bus.dma_run && m_prev;
      m_prev = bus.dma_run;
`ifdef OAM_DMA_CPU_BLOCK_EN
      blk = (m_phase != 0);
`else
      blk = 0;
`endif
      pw   = bus.ppu_rd && bus.ppu_a < 160;
      full = (q.size() == 2);
      popn = !pw && q.size() > 0;
      go   = bus.cpu_sel && !pw && !popn && bus.cpu_a < 160 && !blk;
      if (bus.ppu_rd)
        m_ppu = pw ? m_mem[bus.ppu_a] : 8'hFF;
      if (bus.cpu_sel && bus.cpu_rd)
        m_cpu = (go && !bus.cpu_wr) ? m_mem[bus.cpu_a] : 8'hFF;
      if (popn) begin
        e = q.pop_front();
        m_mem[e.a] = e.d;
      end else if (go && bus.cpu_wr) begin
        m_mem[bus.cpu_a] = bus.cpu_wdata;
      end
      ovset = 0;
      if (m_phase == 1 && bus.dma_strobe) begin
        if (full) begin
          m_ovr = 1;
          ovset = 1;
        end else if (bus.dma_a < 160) begin
          q.push_back({bus.dma_a, bus.dma_wdata});
          if (m_cnt < 160) m_cnt++;
        end
      end
      if (!ovset && bus.cpu_sel && bus.cpu_wr && bus.cpu_a == 8'hFF)
        m_ovr = 0;
      m_done = 0;
      case (m_phase)
        0: if (rise) begin m_phase = 1; m_cnt = 0; end
        1: if (fall || m_cnt == 160) m_phase = 2;
        default: begin
          if (rise) begin
            m_phase = 1;
            m_cnt = 0;
          end else if (q.size() == 0) begin
            m_phase = 0;
            m_done = 1;
          end
        end
      endcase
    end
  end

  always @(negedge clk1) begin
    if (started) begin
      chk("ppu_rdata", bus.ppu_rdata, m_ppu);
      chk("cpu_rdata", bus.cpu_rdata, m_cpu);
      chk("oam_busy", bus.oam_busy, m_phase != 0);
      chk("dma_done", bus.dma_done, m_done);
      chk("overrun", bus.overrun, m_ovr);
      chk("byte_count", bus.byte_count, m_cnt);
      if (bus.dma_done) n_done++;
    end
  end

  task automatic step();
    @(posedge clk1);
    #2;
  endtask

  task automatic idle_in();
    bus.dma_strobe = 0;
    bus.ppu_rd     = 0;
    bus.cpu_sel    = 0;
    bus.cpu_rd     = 0;
    bus.cpu_wr     = 0;
  endtask

  task automatic ppu_read(input logic [7:0] a, input logic [7:0] exp, input string nm);
    bus.ppu_rd = 1;
    bus.ppu_a  = a;
    step();
    bus.ppu_rd = 0;
    chk(nm, bus.ppu_rdata, exp);
  endtask

  task automatic wait_done(input int lim);
    int n0 = n_done;
    for (int i = 0; i < lim && n_done == n0; i++) step();
    chk("done_within_bound", n_done != n0, 1);
  endtask

  logic [7:0] exp_cpu;
  int n0;

  initial begin
    bus.dma_run = 0; bus.dma_a = 0; bus.dma_wdata = 0;
    bus.ppu_a = 0; bus.cpu_a = 0; bus.cpu_wdata = 0;
    idle_in();
    step(); step(); step();
    chk("rst_busy", bus.oam_busy, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 8'hFF);
    chk("rst_ppu_rdata", bus.ppu_rdata, 8'hFF);
    chk("rst_count", bus.byte_count, 0);
    reset = 0;
    step();

    // full transfer
    bus.dma_run = 1;
    step();
    chk("busy_after_rise", bus.oam_busy, 1);
    for (int i = 0; i < 160; i++) begin
      bus.dma_strobe = 1;
      bus.dma_a      = 8'(i);
      bus.dma_wdata  = 8'(i) ^ 8'h5A;
      step();
    end
    bus.dma_strobe = 0;
    chk("full_count", bus.byte_count, 160);
    chk("done_not_yet", bus.dma_done, 0);
    step();
    chk("done_2_after", bus.dma_done, 1);
    chk("busy_falls", bus.oam_busy, 0);
    chk("full_ovr", bus.overrun, 0);
    bus.dma_run = 0;
    step();
    bus.cpu_sel = 1; bus.cpu_rd = 1; bus.cpu_a = 8'h00;
    step();
    chk("rb_00", bus.cpu_rdata, 8'h5A);
    bus.cpu_a = 8'h9F;
    step();
    chk("rb_9f", bus.cpu_rdata, 8'hC5);
    bus.cpu_a = 8'hA5;
    step();
    chk("cpu_oob", bus.cpu_rdata, 8'hFF);
    idle_in();
    ppu_read(8'h45, 8'h1F, "ppu_rb_45");
    ppu_read(8'hA0, 8'hFF, "ppu_oob");

    // out-of-range strobe
    bus.dma_run = 1;
    step();
    bus.dma_strobe = 1; bus.dma_a = 8'h05; bus.dma_wdata = 8'h11;
    step();
    bus.dma_a = 8'hA3; bus.dma_wdata = 8'h77;
    step();
    bus.dma_strobe = 0;
    step();
    chk("oob_count", bus.byte_count, 1);

    // CPU during DMA, port idle
    bus.cpu_sel = 1; bus.cpu_wr = 1; bus.cpu_a = 8'h05; bus.cpu_wdata = 8'h12;
    step();
    bus.cpu_wr = 0; bus.cpu_rd = 1;
    step();
`ifdef OAM_DMA_CPU_BLOCK_EN
    exp_cpu = 8'hFF;
`else
    exp_cpu = 8'h12;
`endif
    chk("cpu_mid_xfer", bus.cpu_rdata, exp_cpu);
    idle_in();

    // PPU contention
    bus.ppu_rd = 1; bus.ppu_a = 8'h10;
    for (int i = 0; i < 3; i++) begin
      bus.dma_strobe = 1;
      bus.dma_a      = 8'h20 + 8'(i);
      bus.dma_wdata  = 8'hC0 + 8'(i);
      step();
    end
    chk("contention_ovr", bus.overrun, 1);
    idle_in();
    bus.cpu_sel = 1; bus.cpu_rd = 1; bus.cpu_a = 8'h20;
    step();
    chk("cpu_lose_pop1", bus.cpu_rdata, 8'hFF);
    step();
    chk("cpu_lose_pop2", bus.cpu_rdata, 8'hFF);
    step();
`ifdef OAM_DMA_CPU_BLOCK_EN
    exp_cpu = 8'hFF;
`else
    exp_cpu = 8'hC0;
`endif
    chk("cpu_after_pops", bus.cpu_rdata, exp_cpu);
    chk("contention_count", bus.byte_count, 3);
    bus.cpu_rd = 0; bus.cpu_wr = 1; bus.cpu_a = 8'hFF;
    step();
    chk("ovr_clear", bus.overrun, 0);
    idle_in();
    ppu_read(8'h21, 8'hC1, "ppu_rb_21");
    ppu_read(8'h22, 8'h78, "ppu_rb_22");

    // restart in DRAIN
    n0 = n_done;
    bus.ppu_rd = 1; bus.ppu_a = 8'h10;
    bus.dma_strobe = 1; bus.dma_a = 8'h30; bus.dma_wdata = 8'hA1;
    step();
    bus.dma_a = 8'h31; bus.dma_wdata = 8'hA2; bus.dma_run = 0;
    step();
    bus.dma_strobe = 0; bus.dma_run = 1;
    step();
    chk("restart_count", bus.byte_count, 0);
    chk("restart_busy", bus.oam_busy, 1);
    bus.ppu_rd = 0;
    step(); step();
    chk("no_early_done", n_done, n0);
    bus.dma_strobe = 1; bus.dma_a = 8'h40; bus.dma_wdata = 8'hB0;
    step();
    bus.dma_strobe = 0; bus.dma_run = 0;
    wait_done(10);
    chk("restart_one_done", n_done, n0 + 1);
    chk("restart_count2", bus.byte_count, 1);
    ppu_read(8'h30, 8'hA1, "ppu_rb_30");
    ppu_read(8'h31, 8'hA2, "ppu_rb_31");
    ppu_read(8'h40, 8'hB0, "ppu_rb_40");

    // reset mid-transfer
    bus.dma_run = 1;
    step();
    bus.dma_strobe = 1; bus.dma_a = 8'h4F; bus.dma_wdata = 8'h99;
    step();
    bus.dma_strobe = 0;
    step();
    bus.ppu_rd = 1; bus.ppu_a = 8'h00;
    bus.dma_strobe = 1; bus.dma_a = 8'h50; bus.dma_wdata = 8'hEE;
    step();
    bus.dma_a = 8'h51; bus.dma_wdata = 8'hEF;
    step();
    idle_in();
    reset = 1;
    step();
    chk("mid_rst_busy", bus.oam_busy, 0);
    chk("mid_rst_count", bus.byte_count, 0);
    chk("mid_rst_ppu", bus.ppu_rdata, 8'hFF);
    chk("mid_rst_cpu", bus.cpu_rdata, 8'hFF);
    reset = 0; bus.dma_run = 0;
    step(); step();
    ppu_read(8'h50, 8'h0A, "lost_50");
    ppu_read(8'h51, 8'h0B, "lost_51");
    ppu_read(8'h4F, 8'h99, "kept_4f");
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
